frame_tick_scheduler: RTL and testbench

//  Multi-channel frame-synchronous tick generator; successor of the single global frame tick.

---
 rtl/frame_tick_pkg.sv | 19 +
 rtl/fts_channel.sv | 49 ++++
 rtl/frame_tick_scheduler.sv | 69 ++++++
 tb/tb_frame_tick_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tick_pkg.sv
// Shared constants for the frame tick scheduler: default sizing and the channel IDs used by
// the game logic.
package frame_tick_pkg;

  localparam int unsigned FTS_NUM_CH      = 4;
  localparam int unsigned FTS_DIV_W       = 8;
  localparam int unsigned FTS_FRAME_CNT_W = 16;

  localparam int unsigned FTS_CH_MARCH = 0;
  localparam int unsigned FTS_CH_SHOT  = 1;
  localparam int unsigned FTS_CH_UFO   = 2;
  localparam int unsigned FTS_CH_BLINK = 3;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned fts_ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/fts_channel.sv
// One tick channel: down-counter reloaded from its period, one-shot latch and registered tick.
module fts_channel #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             ch_enb,
  input  logic             oneshot,
  input  logic             load,
  input  logic [DIV_W-1:0] load_period,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] period_q;
  logic             done_q;
  logic             tick_q;
  logic             qual;

  assign qual = frame && ch_enb && !done_q;
  assign tick = tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      // A load takes priority over a coincident frame: no tick, no decrement.
      if (load) begin
        period_q <= load_period;
        count_q  <= load_period;
        done_q   <= 1'b0;
      end else if (qual) begin
        if (count_q == '0) begin
          tick_q  <= 1'b1;
          count_q <= period_q;
          if (oneshot) done_q <= 1'b1;
        end else begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_tick_scheduler.sv
// Multi-channel frame-synchronous tick generator. Define FTS_FRAME_COUNT_EN to add the
// qualified-frame counter output frame_cnt.
module frame_tick_scheduler
  import frame_tick_pkg::*;
#(
  parameter int unsigned NUM_CH      = FTS_NUM_CH,
  parameter int unsigned DIV_W       = FTS_DIV_W,
`ifdef FTS_FRAME_COUNT_EN
  parameter int unsigned FRAME_CNT_W = FTS_FRAME_CNT_W,
`endif
  localparam int unsigned CH_W       = fts_ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              enb,
  input  logic [NUM_CH-1:0] ch_enb,
  input  logic [NUM_CH-1:0] ch_oneshot,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_period,
`ifdef FTS_FRAME_COUNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic [NUM_CH-1:0] tick
);

  logic load_ready_q;
  logic load_acc;
  logic frame;

  assign load_ready = load_ready_q;
  assign load_acc   = load_valid && load_ready_q;
  assign frame      = frame_start && enb;

  always_ff @(posedge clk) begin
    if (rst) load_ready_q <= 1'b0;
    else     load_ready_q <= 1'b1;
  end

  // Out-of-range load_ch matches no channel, so such a load is accepted and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fts_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .frame      (frame),
      .ch_enb     (ch_enb[i]),
      .oneshot    (ch_oneshot[i]),
      .load       (load_acc && (load_ch == CH_W'(i))),
      .load_period(load_period),
      .tick       (tick[i])
    );
  end

`ifdef FTS_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)        frame_cnt_q <= '0;
    else if (frame) frame_cnt_q <= frame_cnt_q + 1'b1;
  end
`endif

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Directed bench for frame_tick_scheduler: a 4-channel DUT plus a 3-channel DUT used to reach
// an out-of-range load_ch value.
module tb_frame_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       enb = 1'b1;
  logic [3:0] ch_enb = 4'hF;
  logic [3:0] ch_oneshot = 4'h0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_ch = '0;
  logic [7:0] load_period = '0;
  logic [3:0] tick;

  logic       load_valid3 = 1'b0;
  logic       load_ready3;
  logic [1:0] load_ch3 = '0;
  logic [7:0] load_period3 = '0;
  logic [2:0] tick3;

  int checks = 0;
  int errors = 0;
  int fc_exp = 0;

`ifdef FTS_FRAME_COUNT_EN
  logic [3:0] frame_cnt;
  logic [3:0] frame_cnt3;
`endif

  always #5 clk = ~clk;

  frame_tick_scheduler #(
    .NUM_CH(4),
`ifdef FTS_FRAME_COUNT_EN
    .FRAME_CNT_W(4),
`endif
    .DIV_W(8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .enb        (enb),
    .ch_enb     (ch_enb),
    .ch_oneshot (ch_oneshot),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_period(load_period),
`ifdef FTS_FRAME_COUNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .tick       (tick)
  );

  frame_tick_scheduler #(
    .NUM_CH(3),
`ifdef FTS_FRAME_COUNT_EN
    .FRAME_CNT_W(4),
`endif
    .DIV_W(8)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .enb        (enb),
    .ch_enb     (ch_enb[2:0]),
    .ch_oneshot (3'b000),
    .load_valid (load_valid3),
    .load_ready (load_ready3),
    .load_ch    (load_ch3),
    .load_period(load_period3),
`ifdef FTS_FRAME_COUNT_EN
    .frame_cnt  (frame_cnt3),
`endif
    .tick       (tick3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one frame; returns at the negedge where the resulting tick is visible.
  task automatic pulse_frame;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    if (enb) fc_exp++;
  endtask

  task automatic do_frame(input string tag, input logic [3:0] exp);
    pulse_frame();
    check(tag, tick, exp);
    @(negedge clk);
    check({tag, "_gap"}, tick, 4'h0);
  endtask

  task automatic do_load(input logic [1:0] ch, input logic [7:0] p);
    @(negedge clk) begin
      load_valid  = 1'b1;
      load_ch     = ch;
      load_period = p;
    end
    @(negedge clk) load_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    fc_exp = 0;
    check({tag, "_ready_lo"}, load_ready, 1'b0);
    check({tag, "_tick_lo"}, tick, 4'h0);
    @(negedge clk);
    check({tag, "_ready_hi"}, load_ready, 1'b1);
  endtask

  initial begin
    // 1: reset, all periods 0 -> every channel ticks every frame
    repeat (2) @(negedge clk);
    check("rst_tick", tick, 4'h0);
    check("rst_ready", load_ready, 1'b0);
    rst = 1'b0;
    fc_exp = 0;
    @(negedge clk);
    check("ready_rise", load_ready, 1'b1);
    for (int f = 1; f <= 5; f++) do_frame($sformatf("t1_f%0d", f), 4'hF);

    // 2: ch1 P=3 -> ticks on frames 4, 8, 12
    do_load(2'd1, 8'd3);
    for (int f = 1; f <= 12; f++)
      do_frame($sformatf("t2_f%0d", f), (f % 4 == 0) ? 4'hF : 4'hD);

    // 3: one-shot ch2 P=1 -> single tick on frame 2, rearmed by reload
    do_load(2'd1, 8'd0);
    ch_oneshot = 4'b0100;
    do_load(2'd2, 8'd1);
    for (int f = 1; f <= 10; f++)
      do_frame($sformatf("t3_f%0d", f), (f == 2) ? 4'hF : 4'hB);
    do_load(2'd2, 8'd1);
    do_frame("t3_rearm_f1", 4'hB);
    do_frame("t3_rearm_f2", 4'hF);
    do_frame("t3_rearm_f3", 4'hB);
    ch_oneshot = 4'h0;
    do_load(2'd2, 8'd0);

    // 4: load ch0 P=2 coincident with frame_start -> no tick, next tick 3 frames later
    @(negedge clk) begin
      frame_start = 1'b1;
      load_valid  = 1'b1;
      load_ch     = 2'd0;
      load_period = 8'd2;
    end
    @(negedge clk) begin
      frame_start = 1'b0;
      load_valid  = 1'b0;
    end
    fc_exp++;
    check("t4_coincident", tick, 4'hE);
    do_frame("t4_f1", 4'hE);
    do_frame("t4_f2", 4'hE);
    do_frame("t4_f3", 4'hF);

    // 5: enb low 3 frames, ch_enb[3] low 2 frames -> counts frozen
    do_load(2'd3, 8'd2);
    do_frame("t5_a", 4'b0110);
    enb = 1'b0;
    for (int f = 1; f <= 3; f++) do_frame($sformatf("t5_off%0d", f), 4'h0);
    enb = 1'b1;
    ch_enb = 4'b0111;
    do_frame("t5_b", 4'b0110);
    do_frame("t5_c", 4'b0111);
    ch_enb = 4'hF;
    do_frame("t5_d", 4'b0110);
    do_frame("t5_e", 4'b1110);

    // 6: mid-count reset clears counts, periods and one-shot done
    ch_oneshot = 4'b0100;
    do_frame("t6_f", 4'b0111);
    do_frame("t6_g", 4'b0010);
    ch_oneshot = 4'h0;
    do_reset("t6_rst");
    do_frame("t6_post1", 4'hF);
    do_frame("t6_post2", 4'hF);

    // Out-of-range channel on the 3-channel instance: accepted, no effect
    @(negedge clk) begin
      load_valid3  = 1'b1;
      load_ch3     = 2'd3;
      load_period3 = 8'd5;
    end
    check("oor_ready", load_ready3, 1'b1);
    @(negedge clk) load_valid3 = 1'b0;
    pulse_frame();
    check("oor_f1", tick3, 3'b111);
    pulse_frame();
    check("oor_f2", tick3, 3'b111);
    check("oor_ready_after", load_ready3, 1'b1);

    // Maximum period: ch1 P=255 ticks once every 256 frames
    do_load(2'd1, 8'hFF);
    for (int f = 1; f <= 257; f++) begin
      pulse_frame();
      if (f >= 254) check($sformatf("pmax_f%0d", f), tick[1], (f == 256) ? 1'b1 : 1'b0);
    end

`ifdef FTS_FRAME_COUNT_EN
    check("fcnt_mod", frame_cnt, 4'(fc_exp));
    do_reset("fcnt_rst");
    check("fcnt_clr", frame_cnt, 4'd0);
    for (int f = 1; f <= 15; f++) pulse_frame();
    check("fcnt_15", frame_cnt, 4'd15);
    pulse_frame();
    check("fcnt_wrap", frame_cnt, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
